// File: rtl/pwm_pkg.sv
// Shared constants for the PWM family: mode encodings, logic levels and
// the counter direction used by the center-aligned sweep.
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM compare channel: active duty/enable registers, counter compare
// and the registered polarity-adjusted output.
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int pWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_apply,
  input  logic [pWIDTH-1:0] i_duty_src,
  input  logic              i_ch_en_src,
  input  logic [pWIDTH-1:0] i_cnt,
  input  logic              i_run,
  input  logic              i_pol,
  output logic              o_wave
);

  logic [pWIDTH-1:0] r_duty_a;
  logic              r_ch_en_a;
  logic              r_wave;
  logic              w_act;

  // A stopped counter forces every channel inactive, leaving only polarity.
  assign w_act = (i_run == ON) && (r_ch_en_a == ON) && (i_cnt < r_duty_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_a  <= '0;
      r_ch_en_a <= OFF;
      r_wave    <= LOW;
    end else begin
      if (i_apply) begin
        r_duty_a  <= i_duty_src;
        r_ch_en_a <= i_ch_en_src;
      end
      r_wave <= w_act ^ i_pol;
    end
  end

  assign o_wave = r_wave;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared edge/center-aligned counter feeding pCH
// compare channels, with period-boundary double buffering of the setup.
//
// dir      | meaning
// DIR_UP   | counting up (always, in edge mode)
// DIR_DOWN | center mode, sweeping back from P towards 0
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int pCH             = 4,
  parameter int pWIDTH          = 16,
  parameter int pDEFAULT_PERIOD = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [pWIDTH-1:0]     period,
  input  logic [pCH*pWIDTH-1:0] duty,
  input  logic [pCH-1:0]        ch_en,
  input  logic [pCH-1:0]        pol,
  input  logic                  load,
  output logic                  load_pend,
  output logic                  end_tick,
  output logic [pCH-1:0]        wave
);

  localparam logic [pWIDTH-1:0] lp_def_period = pWIDTH'(pDEFAULT_PERIOD);
  localparam logic [pWIDTH-1:0] lp_one        = pWIDTH'(1);

  logic [pWIDTH-1:0]     r_cnt;
  pwm_dir_e              r_dir;
  logic                  r_mode_a;
  logic [pWIDTH-1:0]     r_period_a;
  logic                  r_mode_p;
  logic [pWIDTH-1:0]     r_period_p;
  logic [pCH*pWIDTH-1:0] r_duty_p;
  logic [pCH-1:0]        r_ch_en_p;
  logic                  r_load_pend;
  logic                  r_end_tick;

  logic [pWIDTH-1:0]     w_per_eff;
  logic                  w_boundary;
  logic [pWIDTH-1:0]     w_cnt_nxt;
  pwm_dir_e              w_dir_nxt;
  logic                  w_apply;
  logic                  w_mode_src;
  logic [pWIDTH-1:0]     w_period_src;
  logic [pCH*pWIDTH-1:0] w_duty_src;
  logic [pCH-1:0]        w_ch_en_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  // Center sweep turns down on the cycle that reaches P, so the boundary
  // (down at cnt==1) also covers the degenerate P=1 sequence 0,1,0,1.
  always_comb begin
    w_per_eff  = (r_period_a == '0) ? lp_one : r_period_a;
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    if (r_mode_a == PWM_CENTER)
      w_boundary = (r_dir == DIR_DOWN) && (r_cnt == lp_one);
    else
      w_boundary = (r_cnt == w_per_eff - lp_one);

    if (!en || w_boundary) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (r_mode_a == PWM_CENTER) begin
      if (r_dir == DIR_UP) begin
        w_cnt_nxt = r_cnt + lp_one;
        if (r_cnt + lp_one == w_per_eff)
          w_dir_nxt = DIR_DOWN;
      end else begin
        w_cnt_nxt = r_cnt - lp_one;
      end
    end else begin
      w_cnt_nxt = r_cnt + lp_one;
    end
  end

  // A load landing on the boundary (or while stopped) bypasses the pending copy.
  assign w_apply      = !en || (w_boundary && (load || r_load_pend));
  assign w_mode_src   = load ? mode   : r_mode_p;
  assign w_period_src = load ? period : r_period_p;
  assign w_duty_src   = load ? duty   : r_duty_p;
  assign w_ch_en_src  = load ? ch_en  : r_ch_en_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_a    <= PWM_EDGE;
      r_period_a  <= lp_def_period;
      r_mode_p    <= PWM_EDGE;
      r_period_p  <= '0;
      r_duty_p    <= '0;
      r_ch_en_p   <= '0;
      r_load_pend <= 1'b0;
      r_end_tick  <= LOW;
    end else begin
      if (load) begin
        r_mode_p   <= mode;
        r_period_p <= period;
        r_duty_p   <= duty;
        r_ch_en_p  <= ch_en;
      end
      if (w_apply) begin
        r_mode_a   <= w_mode_src;
        r_period_a <= w_period_src;
      end
      if (!en || w_boundary)
        r_load_pend <= 1'b0;
      else if (load)
        r_load_pend <= 1'b1;
      r_end_tick <= en && w_boundary;
    end
  end

  for (genvar g = 0; g < pCH; g++) begin : g_ch
    pwm_cmp_ch #(
      .pWIDTH (pWIDTH)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_apply     (w_apply),
      .i_duty_src  (w_duty_src[g*pWIDTH +: pWIDTH]),
      .i_ch_en_src (w_ch_en_src[g]),
      .i_cnt       (r_cnt),
      .i_run       (en),
      .i_pol       (pol[g]),
      .o_wave      (wave[g])
    );
  end

  assign load_pend = r_load_pend;
  assign end_tick  = r_end_tick;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios plus a randomized phase, all
// checked every clock against a phase-index reference model.
module tb_pwm_multi_ch;

  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int DEF = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [W-1:0]  period;
  logic [CH*W-1:0] duty;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] pol;
  logic          load;
  logic          load_pend;
  logic          end_tick;
  logic [CH-1:0] wave;

  always #5 clk = ~clk;

  pwm_multi_ch #(
    .pCH             (CH),
    .pWIDTH          (W),
    .pDEFAULT_PERIOD (DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .period    (period),
    .duty      (duty),
    .ch_en     (ch_en),
    .pol       (pol),
    .load      (load),
    .load_pend (load_pend),
    .end_tick  (end_tick),
    .wave      (wave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: active/pending setup plus a phase index k within the cycle.
  int a_mode, a_per, a_duty[CH], a_chen[CH];
  int p_mode, p_per, p_duty[CH], p_chen[CH];
  bit m_pend;
  int m_k;
  logic [CH-1:0] e_wave;
  logic e_end;

  int hi[CH];
  int ends;

  function automatic int eff_p();
    return (a_per == 0) ? 1 : a_per;
  endfunction

  function automatic int cyc_len();
    return (a_mode != 0) ? 2 * eff_p() : eff_p();
  endfunction

  function automatic int cnt_at(int k);
    int p;
    p = eff_p();
    if (a_mode == 0) return k;
    return (k <= p) ? k : 2 * p - k;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    a_mode = 0; a_per = DEF; p_mode = 0; p_per = 0;
    for (int i = 0; i < CH; i++) begin
      a_duty[i] = 0; a_chen[i] = 0; p_duty[i] = 0; p_chen[i] = 0;
    end
    m_pend = 0; m_k = 0; e_wave = '0; e_end = 1'b0;
  endtask

  task automatic apply_inputs();
    a_mode = int'(mode); a_per = int'(period);
    for (int i = 0; i < CH; i++) begin
      a_duty[i] = int'(duty[i*W +: W]); a_chen[i] = int'(ch_en[i]);
    end
  endtask

  task automatic apply_pending();
    a_mode = p_mode; a_per = p_per;
    for (int i = 0; i < CH; i++) begin
      a_duty[i] = p_duty[i]; a_chen[i] = p_chen[i];
    end
  endtask

  task automatic model_step();
    int c;
    bit bnd;
    c   = cnt_at(m_k);
    bnd = en && (m_k == cyc_len() - 1);
    for (int i = 0; i < CH; i++)
      e_wave[i] = ((en && a_chen[i] != 0 && c < a_duty[i]) ? 1'b1 : 1'b0) ^ pol[i];
    e_end = bnd;
    if (!en || bnd) begin
      if (load) apply_inputs();
      else if (!en || m_pend) apply_pending();
      m_k = 0;
      m_pend = 0;
    end else begin
      m_k++;
      if (load) m_pend = 1;
    end
    if (load) begin
      p_mode = int'(mode); p_per = int'(period);
      for (int i = 0; i < CH; i++) begin
        p_duty[i] = int'(duty[i*W +: W]); p_chen[i] = int'(ch_en[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("wave", 32'(wave), 32'(e_wave));
    chk("end_tick", 32'(end_tick), 32'(e_end));
    chk("load_pend", 32'(load_pend), 32'(m_pend));
  endtask

  task automatic clear_counts();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    ends = 0;
  endtask

  task automatic tick_cnt();
    tick();
    for (int i = 0; i < CH; i++) hi[i] += int'(wave[i]);
    ends += int'(end_tick);
  endtask

  task automatic run_count(int n);
    clear_counts();
    repeat (n) tick_cnt();
  endtask

  task automatic set_duty(int i, int v);
    duty[i*W +: W] = W'(v);
  endtask

  task automatic wait_phase(int k);
    for (int n = 0; n < 2100 && m_k != k; n++) tick();
    chk("reach_phase", 32'(m_k), 32'(k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int idx;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; period = '0; duty = '0;
    ch_en = '0; pol = '0; load = 1'b0;
    model_reset();
    #1;
    chk("rst_wave", 32'(wave), 32'h0);
    chk("rst_end", 32'(end_tick), 32'h0);
    chk("rst_pend", 32'(load_pend), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Edge mode, period 10, duties 0/3/10/15
    mode = 1'b0; period = 16'd10; ch_en = 4'hF;
    set_duty(0, 0); set_duty(1, 3); set_duty(2, 10); set_duty(3, 15);
    load = 1'b1; tick(); load = 1'b0;
    en = 1'b1;
    run_count(40);
    chk("edge_hi0", 32'(hi[0]), 32'd0);
    chk("edge_hi1", 32'(hi[1]), 32'd12);
    chk("edge_hi2", 32'(hi[2]), 32'd40);
    chk("edge_hi3", 32'(hi[3]), 32'd40);
    chk("edge_ends", 32'(ends), 32'd4);

    // Center mode, period 8: 16-clock cycle, duty 3 -> cnt 2,1,0,1,2 high
    en = 1'b0; mode = 1'b1; period = 16'd8;
    set_duty(0, 3); set_duty(1, 0); set_duty(2, 8); set_duty(3, 9);
    load = 1'b1; tick(); load = 1'b0;
    en = 1'b1;
    run_count(32);
    chk("ctr_hi0", 32'(hi[0]), 32'd10);
    chk("ctr_hi1", 32'(hi[1]), 32'd0);
    chk("ctr_hi2", 32'(hi[2]), 32'd30);
    chk("ctr_hi3", 32'(hi[3]), 32'd32);
    chk("ctr_ends", 32'(ends), 32'd2);

    // Mid-period duty change 3 -> 7 at cnt 4
    en = 1'b0; mode = 1'b0; period = 16'd10;
    for (int i = 0; i < CH; i++) set_duty(i, 3);
    load = 1'b1; tick(); load = 1'b0;
    en = 1'b1;
    clear_counts();
    repeat (4) tick_cnt();
    set_duty(0, 7);
    load = 1'b1; tick_cnt(); load = 1'b0;
    chk("mid_pend_set", 32'(load_pend), 32'd1);
    repeat (5) tick_cnt();
    chk("mid_hi_old", 32'(hi[0]), 32'd3);
    chk("mid_pend_clr", 32'(load_pend), 32'd0);
    run_count(10);
    chk("mid_hi_new", 32'(hi[0]), 32'd7);

    // Load exactly in the boundary cycle
    wait_phase(9);
    set_duty(0, 5);
    load = 1'b1; tick(); load = 1'b0;
    chk("bnd_pend", 32'(load_pend), 32'd0);
    run_count(10);
    chk("bnd_hi", 32'(hi[0]), 32'd5);

    // Two loads before the boundary: last one wins
    set_duty(0, 2); load = 1'b1; tick();
    set_duty(0, 6); tick(); load = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      found = end_tick;
    end
    chk("dbl_end_seen", 32'(found), 32'd1);
    run_count(10);
    chk("dbl_hi", 32'(hi[0]), 32'd6);

    // Polarity while stopped and while running
    en = 1'b0; pol = 4'b0101;
    repeat (2) tick();
    chk("pol_idle", 32'(wave), 32'h5);
    set_duty(0, 0); load = 1'b1; tick(); load = 1'b0;
    en = 1'b1; pol = 4'b0000;
    repeat (2) tick();
    pol[0] = 1'b1;
    tick();
    chk("pol_toggle", 32'(wave[0]), 32'd1);

    // Randomized phase
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        load = 1'b1;
        mode = 1'($urandom_range(0, 1));
        period = W'($urandom_range(0, 12));
        for (int i = 0; i < CH; i++) set_duty(i, int'($urandom_range(0, 14)));
        ch_en = CH'($urandom);
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) pol = CH'($urandom);
      en = ($urandom_range(0, 39) != 0);
      tick();
    end
    load = 1'b0;

    // Asynchronous reset mid-period with a load pending
    en = 1'b0; mode = 1'b0; period = 16'd10; ch_en = 4'hF;
    for (int i = 0; i < CH; i++) set_duty(i, 4);
    load = 1'b1; tick(); load = 1'b0;
    en = 1'b1; pol = 4'b0011;
    wait_phase(5);
    set_duty(0, 9); load = 1'b1; tick(); load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wave", 32'(wave), 32'h0);
    chk("arst_end", 32'(end_tick), 32'h0);
    chk("arst_pend", 32'(load_pend), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    chk("arst_wave_pol", 32'(wave), 32'h3);
    idx = 1;
    found = end_tick;
    for (int n = 0; n < 1100 && !found; n++) begin
      tick();
      idx++;
      found = end_tick;
    end
    chk("arst_first_end", 32'(idx), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
